// File: rtl/text_pixelgen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : text_pixelgen_pkg
// Purpose : Shared types and defaults for the text-mode pixel generator.
//           Holds the fetch FSM state encoding, the default geometry used
//           as parameter defaults, and a helper that sizes a line-buffer
//           entry ({glyph, attr, cursor_hit}) for a given geometry.
// Revision: 1.0 - initial release
// ============================================================================
package text_pixelgen_pkg;

  localparam int DEF_HTILES  = 80;
  localparam int DEF_GLYPH_W = 8;
  localparam int DEF_GLYPH_H = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FONT  = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4
  } fetch_state_t;

  // Width of one line-buffer entry: glyph row + {bg,fg} attribute + cursor bit
  function automatic int entry_bits(input int glyph_w, input int color_bits);
    return glyph_w + 2 * color_bits + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/text_linebuf.sv
`default_nettype none
// ============================================================================
// Module  : text_linebuf
// Purpose : Two-bank line buffer. One write port, one read port with a
//           single cycle of synchronous read latency. The bank inputs pick
//           which half is accessed so the fetch side and the display side
//           can work on opposite banks.
// Ports   : clk        - clock
//           i_wr_en    - write strobe
//           i_wr_bank  - bank written
//           i_wr_addr  - entry written
//           i_wr_data  - entry data
//           i_rd_bank  - bank read
//           i_rd_addr  - entry read
//           o_rd_data  - registered read data (valid one cycle after address)
// Revision: 1.0 - initial release
// ============================================================================
module text_linebuf #(
  parameter int DEPTH     = 80,
  parameter int WIDTH     = 17,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 i_wr_en,
  input  logic                 i_wr_bank,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]     i_wr_data,
  input  logic                 i_rd_bank,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [WIDTH-1:0]     o_rd_data
);

  // Contents are deliberately not reset so this maps onto block RAM
  logic [WIDTH-1:0] r_mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
    o_rd_data <= r_mem[i_rd_bank][i_rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/text_pixelgen.sv
`default_nettype none
// ============================================================================
// Module  : text_pixelgen
// Purpose : Text-mode pixel generator. Prefetches the next scanline (char,
//           attribute, font row) into one bank of a ping-pong line buffer
//           while the other bank is shifted out as colour indices, with
//           per-cell fg/bg, character blink and a hardware cursor.
// Ports   : clk, rst_n            - pixel clock, synchronous active-low reset
//           line_start/frame_start - timing pulses from the VGA timing block
//           visible                - active pixel window
//           next_row               - pixel line to prefetch (taken on line_start)
//           vram_*                 - character/attribute read handshake
//           font_addr/font_data    - synchronous font ROM ({char, glyph_row})
//           cursor_*               - hardware cursor position/enable
//           pixel                  - registered colour index
//           underrun               - sticky: prefetch unfinished at line_start
// Revision: 1.0 - initial release
// ============================================================================
module text_pixelgen
  import text_pixelgen_pkg::*;
#(
  parameter int HTILES       = DEF_HTILES,
  parameter int GLYPH_W      = DEF_GLYPH_W,
  parameter int GLYPH_H      = DEF_GLYPH_H,
  parameter int ROW_BITS     = 10,
  parameter int COLOR_BITS   = 4,
  parameter int BLINK_FRAMES = 16,
  parameter int CURSOR_START = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            line_start,
  input  logic                            frame_start,
  input  logic                            visible,
  input  logic [ROW_BITS-1:0]             next_row,
  output logic                            vram_req,
  output logic [$clog2(HTILES)-1:0]       vram_col,
  output logic [ROW_BITS-1:0]             vram_trow,
  input  logic                            vram_ack,
  input  logic [7:0]                      vram_char,
  input  logic [2*COLOR_BITS-1:0]         vram_attr,
  output logic [8+$clog2(GLYPH_H)-1:0]    font_addr,
  input  logic [GLYPH_W-1:0]              font_data,
  input  logic                            cursor_en,
  input  logic [$clog2(HTILES)-1:0]       cursor_col,
  input  logic [ROW_BITS-1:0]             cursor_trow,
  output logic [COLOR_BITS-1:0]           pixel,
  output logic                            underrun
);

  localparam int COL_BITS   = $clog2(HTILES);
  localparam int GROW_BITS  = $clog2(GLYPH_H);
  localparam int PIX_BITS   = $clog2(GLYPH_W);
  localparam int ATTR_BITS  = 2 * COLOR_BITS;
  localparam int ENTRY_BITS = entry_bits(GLYPH_W, COLOR_BITS);
  localparam int BLINK_BITS = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [COL_BITS-1:0]   LAST_COL   = COL_BITS'(HTILES - 1);
  localparam logic [PIX_BITS-1:0]   LAST_PIX   = PIX_BITS'(GLYPH_W - 1);
  localparam logic [BLINK_BITS-1:0] LAST_BLINK = BLINK_BITS'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [GLYPH_W-1:0]   glyph;
    logic [ATTR_BITS-1:0] attr;
    logic                 cursor_hit;
  } entry_t;

  // ---------------------------------------------------------------- fetch side
  fetch_state_t          r_state;
  logic                  r_bank;      // bank currently being displayed
  logic [GROW_BITS-1:0]  r_grow;
  logic [7:0]            r_char;
  logic [ATTR_BITS-1:0]  r_attr;

  logic                  w_wr_en;
  logic                  w_wr_bank;
  logic                  w_hit;
  entry_t                w_wr_entry;

  // vram_col / vram_trow double as the fetch column and latched text row
  assign w_hit = cursor_en
               & (vram_col == cursor_col)
               & (vram_trow == cursor_trow)
               & (int'(r_grow) >= CURSOR_START);

  // A WRITE coinciding with line_start would land in the bank about to be
  // shown, so it is dropped; that cell is refetched from column 0 anyway.
  assign w_wr_en    = (r_state == WRITE) & ~line_start;
  assign w_wr_bank  = ~r_bank;
  assign w_wr_entry = '{glyph: font_data, attr: r_attr, cursor_hit: w_hit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bank    <= 1'b0;
      r_grow    <= '0;
      r_char    <= '0;
      r_attr    <= '0;
      vram_req  <= 1'b0;
      vram_col  <= '0;
      vram_trow <= '0;
      font_addr <= '0;
      underrun  <= 1'b0;
    end else if (line_start) begin
      if (r_state != IDLE) begin
        underrun <= 1'b1;
      end
      r_bank    <= ~r_bank;
      vram_trow <= next_row >> GROW_BITS;
      r_grow    <= next_row[GROW_BITS-1:0];
      vram_col  <= '0;
      vram_req  <= 1'b1;
      r_state   <= REQ;
    end else begin
      case (r_state)
        IDLE: begin
          vram_req <= 1'b0;
        end
        REQ: begin
          if (vram_ack) begin
            r_char   <= vram_char;
            r_attr   <= vram_attr;
            vram_req <= 1'b0;
            r_state  <= FONT;
          end
        end
        FONT: begin
          font_addr <= {r_char, r_grow};
          r_state   <= WAIT;
        end
        WAIT: begin
          // font_data for the address issued in FONT lands during WRITE
          r_state <= WRITE;
        end
        WRITE: begin
          if (vram_col == LAST_COL) begin
            r_state <= IDLE;
          end else begin
            vram_col <= vram_col + COL_BITS'(1);
            vram_req <= 1'b1;
            r_state  <= REQ;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------- line buffer
  entry_t               w_rd_entry;
  logic                 w_rd_bank;
  logic [COL_BITS-1:0]  w_rd_addr;
  logic [COL_BITS-1:0]  w_next_cell;
  logic [COL_BITS-1:0]  r_cell;

  // The read port always looks one cell ahead so the next entry is ready
  // whenever a cell finishes; on line_start it fetches entry 0 of the bank
  // that becomes active on this edge.
  assign w_next_cell = (r_cell == LAST_COL) ? r_cell : r_cell + COL_BITS'(1);
  assign w_rd_bank   = line_start ? ~r_bank : r_bank;
  assign w_rd_addr   = line_start ? '0 : w_next_cell;

  text_linebuf #(
    .DEPTH     (HTILES),
    .WIDTH     (ENTRY_BITS),
    .ADDR_BITS (COL_BITS)
  ) u_linebuf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_bank (w_wr_bank),
    .i_wr_addr (vram_col),
    .i_wr_data (w_wr_entry),
    .i_rd_bank (w_rd_bank),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_entry)
  );

  // ---------------------------------------------------------- display side
  logic [GLYPH_W-1:0]    r_shift;
  logic [ATTR_BITS-1:0]  r_cur_attr;
  logic                  r_cur_hit;
  logic [PIX_BITS-1:0]   r_pix;
  logic                  r_load;
  logic                  r_phase;     // 1 = blink "on" half
  logic [BLINK_BITS-1:0] r_blink_cnt;

  logic [COLOR_BITS-1:0] w_fg;
  logic [COLOR_BITS-1:0] w_bg;
  logic                  w_bit;
  logic                  w_swap;
  logic [COLOR_BITS-1:0] w_color;

  // The bg MSB is the blink enable, not part of the colour
  assign w_fg    = r_cur_attr[COLOR_BITS-1:0];
  assign w_bg    = {1'b0, r_cur_attr[ATTR_BITS-2:COLOR_BITS]};
  assign w_bit   = r_shift[0] & ~(r_cur_attr[ATTR_BITS-1] & ~r_phase);
  assign w_swap  = r_cur_hit & r_phase;
  assign w_color = (w_bit ^ w_swap) ? w_fg : w_bg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_cur_attr <= '0;
      r_cur_hit  <= 1'b0;
      r_pix      <= '0;
      r_cell     <= '0;
      r_load     <= 1'b0;
      pixel      <= '0;
    end else begin
      r_load <= line_start;
      pixel  <= visible ? w_color : '0;
      if (r_load) begin
        r_shift    <= w_rd_entry.glyph;
        r_cur_attr <= w_rd_entry.attr;
        r_cur_hit  <= w_rd_entry.cursor_hit;
        r_pix      <= '0;
      end else if (visible) begin
        if (r_pix == LAST_PIX) begin
          r_shift    <= w_rd_entry.glyph;
          r_cur_attr <= w_rd_entry.attr;
          r_cur_hit  <= w_rd_entry.cursor_hit;
          r_pix      <= '0;
          r_cell     <= w_next_cell;
        end else begin
          r_shift <= r_shift >> 1;
          r_pix   <= r_pix + PIX_BITS'(1);
        end
      end
      if (line_start) begin
        r_cell <= '0;
      end
    end
  end

  // ---------------------------------------------------------- blink timer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase     <= 1'b1;
      r_blink_cnt <= '0;
    end else if (frame_start) begin
      if (r_blink_cnt == LAST_BLINK) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_BITS'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_text_pixelgen.sv
`default_nettype none
// ============================================================================
// Module  : tb_text_pixelgen
// Purpose : Scoreboard bench for text_pixelgen (HTILES=4, 8x8 glyphs).
//           Stimulus pushes expected pixels into a queue; a monitor pops and
//           compares them one cycle after each visible cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_text_pixelgen;

  localparam int HT = 4;
  localparam int RB = 10;
  localparam int BF = 16;
  localparam int CS = 6;

  logic          clk;
  logic          rst_n;
  logic          line_start;
  logic          frame_start;
  logic          visible;
  logic [RB-1:0] next_row;
  logic          vram_req;
  logic [1:0]    vram_col;
  logic [RB-1:0] vram_trow;
  logic          vram_ack;
  logic [7:0]    vram_char;
  logic [7:0]    vram_attr;
  logic [10:0]   font_addr;
  logic [7:0]    font_data;
  logic          cursor_en;
  logic [1:0]    cursor_col;
  logic [RB-1:0] cursor_trow;
  logic [3:0]    pixel;
  logic          underrun;

  logic          ack_en;
  logic [7:0]    cur_attr;
  logic          vis_d;
  logic [3:0]    exp_q[$];
  int            total;
  int            bad;

  // model state: line being prefetched and line being shown
  logic [7:0]    pend_g[HT];
  logic [7:0]    shown_g[HT];
  logic [7:0]    pend_a;
  logic [7:0]    shown_a;
  bit            pend_c[HT];
  bit            shown_c[HT];
  bit            ph;
  int            fcnt;

  text_pixelgen #(
    .HTILES(HT), .GLYPH_W(8), .GLYPH_H(8), .ROW_BITS(RB),
    .COLOR_BITS(4), .BLINK_FRAMES(BF), .CURSOR_START(CS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .frame_start(frame_start),
    .visible(visible), .next_row(next_row), .vram_req(vram_req), .vram_col(vram_col),
    .vram_trow(vram_trow), .vram_ack(vram_ack), .vram_char(vram_char),
    .vram_attr(vram_attr), .font_addr(font_addr), .font_data(font_data),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_trow(cursor_trow),
    .pixel(pixel), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // text RAM: 'A'+col for text row 2, distinct characters for other rows
  function automatic logic [7:0] char_of(input logic [1:0] col, input logic [RB-1:0] trow);
    return 8'h41 + {6'b0, col} + {trow[5:0] ^ 6'd2, 2'b00};
  endfunction

  assign vram_ack  = vram_req & ack_en;
  assign vram_char = char_of(vram_col, vram_trow);
  assign vram_attr = cur_attr;

  // font ROM: every glyph row equals the character code
  always @(posedge clk) font_data <= font_addr[10:3];

  function automatic logic [3:0] pix_of(input logic [7:0] g, input logic [7:0] a,
                                        input bit c, input int i, input bit p);
    logic       b;
    logic [3:0] fg;
    logic [3:0] bg;
    fg = a[3:0];
    bg = {1'b0, a[6:4]};
    b  = g[i] && !(a[7] && !p);
    if (c && p) b = !b;
    return b ? fg : bg;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic frame_model();
    if (fcnt == BF - 1) begin
      fcnt = 0;
      ph   = ~ph;
    end else begin
      fcnt++;
    end
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_start = 1'b1;
      frame_model();
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
    end
  endtask

  // One line: pulse line_start (optionally with frame_start), optionally show
  // 32 visible pixels from cycle 2, and return at the start of cycle 'gap'.
  task automatic do_line(input logic [RB-1:0] row, input bit show, input int gap, input bit fs);
    int n;
    line_start  = 1'b1;
    next_row    = row;
    frame_start = fs;
    if (fs) frame_model();
    shown_g = pend_g;
    shown_a = pend_a;
    shown_c = pend_c;
    pend_a  = cur_attr;
    for (int c = 0; c < HT; c++) begin
      pend_g[c] = char_of(2'(c), row >> 3);
      pend_c[c] = cursor_en && (2'(c) == cursor_col) && ((row >> 3) == cursor_trow)
                  && (int'(row[2:0]) >= CS);
    end
    @(negedge clk);
    line_start  = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
    n = 2;
    if (show) begin
      for (int c = 0; c < HT; c++) begin
        for (int i = 0; i < 8; i++) begin
          exp_q.push_back(pix_of(shown_g[c], shown_a, shown_c[c], i, ph));
          visible = 1'b1;
          @(negedge clk);
        end
      end
      visible = 1'b0;
      n += 32;
    end
    while (n < gap) begin
      @(negedge clk);
      n++;
    end
  endtask

  // monitor: pixel for a visible cycle appears on the following cycle
  always @(posedge clk) vis_d <= visible & rst_n;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (vis_d) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pixel_extra: got %0h expected none", pixel);
        end else begin
          check("pixel", 32'(pixel), 32'(exp_q.pop_front()));
        end
      end else begin
        check("pixel_idle", 32'(pixel), 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    total = 0; bad = 0;
    rst_n = 1'b0; line_start = 1'b0; frame_start = 1'b0; visible = 1'b0;
    next_row = '0; ack_en = 1'b1; cur_attr = 8'h1F;
    cursor_en = 1'b0; cursor_col = '0; cursor_trow = '0;
    ph = 1'b1; fcnt = 0; pend_a = '0;
    for (int c = 0; c < HT; c++) begin pend_g[c] = '0; pend_c[c] = 1'b0; end

    repeat (3) @(negedge clk);
    check("rst_pixel", 32'(pixel), 32'd0);
    check("rst_vram_req", 32'(vram_req), 32'd0);
    check("rst_vram_col", 32'(vram_col), 32'd0);
    check("rst_vram_trow", 32'(vram_trow), 32'd0);
    check("rst_font_addr", 32'(font_addr), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;

    // reset in the middle of a fetch
    line_start = 1'b1; next_row = 10'd19;
    @(negedge clk);
    line_start = 1'b0;
    n = 0;
    while (vram_col != 2'd2 && n < 50) begin @(negedge clk); n++; end
    check("midfetch_reach_col2", 32'(n < 50), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_vram_req", 32'(vram_req), 32'd0);
    check("midrst_underrun", 32'(underrun), 32'd0);
    check("midrst_pixel", 32'(pixel), 32'd0);
    check("midrst_vram_col", 32'(vram_col), 32'd0);
    repeat (5) @(negedge clk);
    check("midrst_idle", 32'(vram_req), 32'd0);

    // basic fetch + display, row 19 -> trow 2, grow 3
    do_line(10'd19, 1'b0, 18, 1'b0);
    check("basic_trow", 32'(vram_trow), 32'd2);
    check("basic_grow", 32'(font_addr[2:0]), 32'd3);
    check("basic_font_char", 32'(font_addr[10:3]), 32'h44);
    check("basic_last_col", 32'(vram_col), 32'd3);
    do_line(10'd27, 1'b1, 40, 1'b0);
    check("row27_trow", 32'(vram_trow), 32'd3);
    do_line(10'd16, 1'b1, 40, 1'b0);

    // back-to-back lines at minimum spacing
    do_line(10'd8, 1'b0, 4 * HT + 2, 1'b0);
    check("b2b_underrun0", 32'(underrun), 32'd0);
    do_line(10'd33, 1'b0, 4 * HT + 2, 1'b0);
    check("b2b_underrun1", 32'(underrun), 32'd0);
    do_line(10'd40, 1'b0, 4 * HT + 2, 1'b0);
    check("b2b_underrun2", 32'(underrun), 32'd0);
    check("b2b_trow", 32'(vram_trow), 32'd5);
    do_line(10'd0, 1'b1, 40, 1'b0);

    // cursor at col 2, trow 2
    cursor_en = 1'b1; cursor_col = 2'd2; cursor_trow = 10'd2;
    do_line(10'd22, 1'b1, 40, 1'b0);
    do_line(10'd19, 1'b1, 40, 1'b0);
    do_line(10'd22, 1'b1, 40, 1'b0);
    frames(BF);
    do_line(10'd22, 1'b1, 40, 1'b0);
    frames(BF);
    cursor_en = 1'b0;

    // blink attribute; last phase flip coincides with line_start
    cur_attr = 8'h9F;
    do_line(10'd19, 1'b1, 40, 1'b0);
    do_line(10'd19, 1'b1, 40, 1'b0);
    frames(BF - 1);
    do_line(10'd19, 1'b1, 40, 1'b1);
    frames(BF);
    do_line(10'd19, 1'b1, 40, 1'b0);

    // underrun: vram never acks, then a new line_start arrives
    cur_attr = 8'h1F;
    ack_en = 1'b0;
    do_line(10'd19, 1'b0, 200, 1'b0);
    check("stall_no_underrun", 32'(underrun), 32'd0);
    check("stall_req_held", 32'(vram_req), 32'd1);
    ack_en = 1'b1;
    do_line(10'd27, 1'b0, 18, 1'b0);
    check("underrun_set", 32'(underrun), 32'd1);
    do_line(10'd16, 1'b1, 40, 1'b0);
    check("underrun_sticky", 32'(underrun), 32'd1);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
